tdc_hit_buffer: RTL

- Downstream stage of the TDC encoder. Captures each encoded hit (TOA, TOT, Cal codes plus error flags) into a small FIFO.
- On a readout trigger, emits one frame over a valid/ready stream: a header word, the hits buffered at trigger time, then a trailer word.
- Sits between the encoder outputs and the pixel readout serializer; a single clock domain, RawdataWrtClk.

---
 rtl/tdc_readout_pkg.sv | 32 +++
 rtl/tdc_hit_fifo.sv | 58 +++++
 rtl/tdc_hit_buffer.sv | 116 +++++++++++
 3 files changed

// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC readout path: word types, field widths,
// FSM states and frame-word builders.
package tdc_readout_pkg;

    localparam logic [1:0] HDR = 2'b00;
    localparam logic [1:0] HIT = 2'b10;
    localparam logic [1:0] TRL = 2'b11;

    localparam int TOA_W = 10;
    localparam int TOT_W = 9;
    localparam int CAL_W = 10;
    localparam int EVT_W = 12;
    localparam int CNT_W = 8;
    localparam int HIT_W = 1 + TOA_W + TOT_W + CAL_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        DATA    = 2'd2,
        TRAILER = 2'd3
    } rdState_e;

    function automatic logic [31:0] headerWord(input logic [EVT_W-1:0] evt,
                                               input logic [CNT_W-1:0] nHits);
        return {HDR, evt, 10'd0, nHits};
    endfunction

    function automatic logic [31:0] trailerWord(input logic [CNT_W-1:0] ovf);
        return {TRL, 22'd0, ovf};
    endfunction

endpackage

// File: rtl/tdc_hit_fifo.sv
// Synchronous hit FIFO with wrap-bit pointers, registered count/full/empty,
// and a look-ahead port exposing the entry behind the head.
module tdc_hit_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 30
) (
    input  logic                RawdataWrtClk,
    input  logic                ResetFlag,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wrData,
    output logic [WIDTH-1:0]    headData,
    output logic [WIDTH-1:0]    nextData,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wrPtr, rdPtr, wrPtrN, rdPtrN, rdPtrInc;
    logic                doPush, doPop;

    // A pop in the same cycle frees the slot, so full does not block that push.
    always_comb begin
        doPop    = pop & ~empty;
        doPush   = push & (~full | doPop);
        rdPtrInc = rdPtr + PTR_ONE;
        wrPtrN   = doPush ? wrPtr + PTR_ONE : wrPtr;
        rdPtrN   = doPop ? rdPtrInc : rdPtr;
    end

    assign headData = mem[rdPtr[DEPTH_LOG2-1:0]];
    assign nextData = mem[rdPtrInc[DEPTH_LOG2-1:0]];

    always_ff @(posedge RawdataWrtClk) begin
        if (doPush) mem[wrPtr[DEPTH_LOG2-1:0]] <= wrData;
    end

    always_ff @(posedge RawdataWrtClk or negedge ResetFlag) begin
        if (!ResetFlag) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wrPtr <= wrPtrN;
            rdPtr <= rdPtrN;
            count <= wrPtrN - rdPtrN;
            full  <= (wrPtrN[DEPTH_LOG2] != rdPtrN[DEPTH_LOG2]) &&
                     (wrPtrN[DEPTH_LOG2-1:0] == rdPtrN[DEPTH_LOG2-1:0]);
            empty <= (wrPtrN == rdPtrN);
        end
    end

endmodule

// File: rtl/tdc_hit_buffer.sv
// Buffers encoded TDC hits and, on a readout trigger, streams one frame:
// header, the hits held at trigger time, then a trailer.
module tdc_hit_buffer
    import tdc_readout_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                RawdataWrtClk,
    input  logic                ResetFlag,
    input  logic                encValid,
    input  logic [TOA_W-1:0]    TOA_code,
    input  logic [TOT_W-1:0]    TOT_code,
    input  logic [CAL_W-1:0]    Cal_code,
    input  logic                TOAerr,
    input  logic                TOTerr,
    input  logic                Calerr,
    input  logic                rdTrigger,
    output logic [31:0]         dout,
    output logic                doutValid,
    input  logic                doutReady,
    output logic                busy,
    output logic [DEPTH_LOG2:0] fifoCount,
    output rdState_e            fsmState
);
    localparam logic [DEPTH_LOG2:0] REM_ONE = 1;

    rdState_e            state;
    logic [DEPTH_LOG2:0] remaining;
    logic [EVT_W-1:0]    eventCount;
    logic [CNT_W-1:0]    ovfCount;
    logic [HIT_W-1:0]    hitWord, fifoHead, fifoNext;
    logic                accept, fifoPop, fifoFull, fifoEmpty, drop;

    // Stream handshake: a word transfers on a rising edge where doutValid and
    // doutReady are both high; while valid and not ready, dout is held unchanged.
    always_comb begin
        hitWord = {TOAerr | TOTerr | Calerr, TOA_code, TOT_code, Cal_code};
        accept  = doutValid & doutReady;
        fifoPop = (state == DATA) & accept & ~fifoEmpty;
        drop    = encValid & fifoFull & ~fifoPop;
    end

    assign fsmState = state;

    tdc_hit_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (HIT_W)
    ) u_fifo (
        .RawdataWrtClk(RawdataWrtClk),
        .ResetFlag    (ResetFlag),
        .push         (encValid),
        .pop          (fifoPop),
        .wrData       (hitWord),
        .headData     (fifoHead),
        .nextData     (fifoNext),
        .count        (fifoCount),
        .full         (fifoFull),
        .empty        (fifoEmpty)
    );

    always_ff @(posedge RawdataWrtClk or negedge ResetFlag) begin
        if (!ResetFlag) begin
            state      <= IDLE;
            dout       <= '0;
            doutValid  <= 1'b0;
            busy       <= 1'b0;
            remaining  <= '0;
            eventCount <= '0;
            ovfCount   <= '0;
        end else begin
            if (state == TRAILER && accept)
                ovfCount <= drop ? 8'd1 : 8'd0;
            else if (drop && ovfCount != 8'hFF)
                ovfCount <= ovfCount + 8'd1;

            case (state)
                IDLE: if (rdTrigger) begin
                    remaining <= fifoCount;
                    dout      <= headerWord(eventCount, CNT_W'(fifoCount));
                    doutValid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= HEADER;
                end
                HEADER: if (accept) begin
                    if (remaining != '0) begin
                        dout  <= {HIT, fifoHead};
                        state <= DATA;
                    end else begin
                        dout  <= trailerWord(ovfCount);
                        state <= TRAILER;
                    end
                end
                // The head is popped on this accept, so the next word is the
                // entry behind it; it was buffered at trigger time.
                DATA: if (accept) begin
                    remaining <= remaining - REM_ONE;
                    if (remaining == REM_ONE) begin
                        dout  <= trailerWord(ovfCount);
                        state <= TRAILER;
                    end else begin
                        dout <= {HIT, fifoNext};
                    end
                end
                TRAILER: if (accept) begin
                    eventCount <= eventCount + 12'd1;
                    dout       <= '0;
                    doutValid  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
